wb_stage: RTL and testbench

- Write-back stage of the GenshinMIPS pipeline, and the writer side of the register-file write port.
- Accepts retiring instructions from MEM via a valid/allowin handshake.
- For loads, waits for the variable-latency data-SRAM response, then aligns and extends the returned word.
- Drives registered we/waddr/wdata into the register file, plus the NSCSCC debug write-back trace.

---
 rtl/wb_stage.sv | 155 +++++++++++++++
 tb/tb_wb_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: retires MEM instructions, waits out load responses,
// and drives the registered GPR write port plus the debug trace.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_valid,
    output logic        wb_allowin,
    input  logic [31:0] mem_pc,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_addr_lo,
    input  logic        data_ok,
    input  logic [31:0] data_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    state_t state;
    state_t state_nxt;

    logic [31:0] ld_pc;
    logic        ld_wreg;
    logic [4:0]  ld_waddr;
    logic [2:0]  ld_type;
    logic [1:0]  ld_lo;

    logic        accept;
    logic        ld_latch;
    logic        wr_upd;
    logic        wr_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;

    // Align the returned word to the addressed byte/halfword and extend it.
    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [2:0]  t,
        input logic [1:0]  lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (t)
            LT_LB:   extract = {{24{b[7]}}, b};
            LT_LBU:  extract = {24'd0, b};
            LT_LH:   extract = {{16{h[15]}}, h};
            LT_LHU:  extract = {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    assign wb_allowin = (state == IDLE) && !flush;
    assign accept     = mem_valid && wb_allowin;

    // Next state and the value to present on the write port next cycle.
    always_comb begin
        state_nxt = state;
        ld_latch  = 1'b0;
        wr_upd    = 1'b0;
        wr_we     = 1'b0;
        wr_addr   = rf_waddr;
        wr_data   = rf_wdata;
        wr_pc     = debug_wb_pc;
        unique case (state)
            IDLE: begin
                if (accept && mem_is_load) begin
                    ld_latch  = 1'b1;
                    state_nxt = WAIT_DATA;
                end else if (accept) begin
                    wr_upd  = 1'b1;
                    wr_we   = mem_wreg && (mem_waddr != 5'd0);
                    wr_addr = mem_waddr;
                    wr_data = mem_wdata;
                    wr_pc   = mem_pc;
                end
            end
            WAIT_DATA: begin
                if (flush) begin
                    state_nxt = data_ok ? IDLE : DRAIN;
                end else if (data_ok) begin
                    wr_upd    = 1'b1;
                    wr_we     = ld_wreg && (ld_waddr != 5'd0);
                    wr_addr   = ld_waddr;
                    wr_data   = extract(data_rdata, ld_type, ld_lo);
                    wr_pc     = ld_pc;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pending-load fields and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ld_pc       <= 32'd0;
            ld_wreg     <= 1'b0;
            ld_waddr    <= 5'd0;
            ld_type     <= 3'd0;
            ld_lo       <= 2'd0;
            rf_we       <= 1'b0;
            rf_waddr    <= 5'd0;
            rf_wdata    <= 32'd0;
            debug_wb_pc <= 32'd0;
        end else begin
            state <= state_nxt;
            rf_we <= wr_we;
            if (ld_latch) begin
                ld_pc    <= mem_pc;
                ld_wreg  <= mem_wreg;
                ld_waddr <= mem_waddr;
                ld_type  <= mem_load_type;
                ld_lo    <= mem_addr_lo;
            end
            if (wr_upd) begin
                rf_waddr    <= wr_addr;
                rf_wdata    <= wr_data;
                debug_wb_pc <= wr_pc;
            end
        end
    end

    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table driven through a scoreboard queue,
// plus a hand-written reset-during-load sequence.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        mem_valid;
    logic        wb_allowin;
    logic [31:0] mem_pc;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic        data_ok;
    logic [31:0] data_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .mem_valid         (mem_valid),
        .wb_allowin        (wb_allowin),
        .mem_pc            (mem_pc),
        .mem_wreg          (mem_wreg),
        .mem_waddr         (mem_waddr),
        .mem_wdata         (mem_wdata),
        .mem_is_load       (mem_is_load),
        .mem_load_type     (mem_load_type),
        .mem_addr_lo       (mem_addr_lo),
        .data_ok           (data_ok),
        .data_rdata        (data_rdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [31:0] pc;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ld;
        logic [2:0]  lt;
        logic [1:0]  lo;
        logic        dok;
        logic [31:0] rdata;
        logic        e_allow;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic vec_t V(
        input logic [31:0] va, input logic [31:0] fl,
        input logic [31:0] pc, input logic [31:0] wr,
        input logic [31:0] wa, input logic [31:0] wd,
        input logic [31:0] ld, input logic [31:0] lt,
        input logic [31:0] lo, input logic [31:0] dk,
        input logic [31:0] rd, input logic [31:0] ea,
        input logic [31:0] ew, input logic [31:0] ewa,
        input logic [31:0] ewd, input logic [31:0] epc
    );
        vec_t v;
        v.valid   = va[0];
        v.flush   = fl[0];
        v.pc      = pc;
        v.wreg    = wr[0];
        v.waddr   = wa[4:0];
        v.wdata   = wd;
        v.ld      = ld[0];
        v.lt      = lt[2:0];
        v.lo      = lo[1:0];
        v.dok     = dk[0];
        v.rdata   = rd;
        v.e_allow = ea[0];
        v.e_we    = ew[0];
        v.e_waddr = ewa[4:0];
        v.e_wdata = ewd;
        v.e_pc    = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush         = 1'b0;
        mem_valid     = 1'b0;
        mem_pc        = 32'd0;
        mem_wreg      = 1'b0;
        mem_waddr     = 5'd0;
        mem_wdata     = 32'd0;
        mem_is_load   = 1'b0;
        mem_load_type = 3'd0;
        mem_addr_lo   = 2'd0;
        data_ok       = 1'b0;
        data_rdata    = 32'd0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        flush         = v.flush;
        mem_valid     = v.valid;
        mem_pc        = v.pc;
        mem_wreg      = v.wreg;
        mem_waddr     = v.waddr;
        mem_wdata     = v.wdata;
        mem_is_load   = v.ld;
        mem_load_type = v.lt;
        mem_addr_lo   = v.lo;
        data_ok       = v.dok;
        data_rdata    = v.rdata;
        #1;
        chk($sformatf("v%0d.allowin", idx), 32'(wb_allowin),
            32'(v.e_allow));
        sb.push_back(v);
        @(posedge clk);
        #1;
        nvec++;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL v%0d.sb: got empty want entry", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d.we", idx), 32'(rf_we), 32'(e.e_we));
            chk($sformatf("v%0d.waddr", idx), 32'(rf_waddr),
                32'(e.e_waddr));
            chk($sformatf("v%0d.wdata", idx), rf_wdata, e.e_wdata);
            chk($sformatf("v%0d.pc", idx), debug_wb_pc, e.e_pc);
            chk($sformatf("v%0d.dwen", idx), 32'(debug_wb_rf_wen),
                32'({4{e.e_we}}));
            chk($sformatf("v%0d.dwnum", idx), 32'(debug_wb_rf_wnum),
                32'(e.e_waddr));
            chk($sformatf("v%0d.dwdata", idx), debug_wb_rf_wdata,
                e.e_wdata);
        end
    endtask

    initial begin
        // va fl pc wr wa wd ld lt lo dk rd | ea ew ewa ewd epc
        vecs.push_back(V(1,0,'h100,1,3,'h11,0,0,0,0,0, 1,1,3,'h11,'h100));
        vecs.push_back(V(1,0,'h104,1,4,'h22,0,0,0,0,0, 1,1,4,'h22,'h104));
        vecs.push_back(V(1,0,'h108,1,5,0,1,1,2,0,0, 1,0,4,'h22,'h104));
        vecs.push_back(V(1,0,'h1F0,1,7,'h77,0,0,0,0,0, 0,0,4,'h22,'h104));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,0,0, 0,0,4,'h22,'h104));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'h1280FF00,
                         0,1,5,'hFFFFFF80,'h108));
        vecs.push_back(V(1,0,'h10C,1,6,0,1,4,2,0,0,
                         1,0,5,'hFFFFFF80,'h108));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'h1280FF00,
                         0,1,6,'h1280,'h10C));
        vecs.push_back(V(1,0,'h110,1,7,0,1,3,0,0,0, 1,0,6,'h1280,'h10C));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'h12348001,
                         0,1,7,'hFFFF8001,'h110));
        vecs.push_back(V(1,0,'h114,1,8,0,1,2,3,0,0,
                         1,0,7,'hFFFF8001,'h110));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'hAB0000CD,
                         0,1,8,'hAB,'h114));
        vecs.push_back(V(1,0,'h118,1,0,0,1,0,0,0,0, 1,0,8,'hAB,'h114));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'hDEADBEEF,
                         0,0,0,'hDEADBEEF,'h118));
        vecs.push_back(V(1,0,'h11C,1,0,'h55,0,0,0,0,0, 1,0,0,'h55,'h11C));
        vecs.push_back(V(1,0,'h120,1,9,0,1,0,0,0,0, 1,0,0,'h55,'h11C));
        vecs.push_back(V(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,'h55,'h11C));
        vecs.push_back(V(0,1,0,0,0,0,0,0,0,0,0, 0,0,0,'h55,'h11C));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'h99999999,
                         0,0,0,'h55,'h11C));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,'h55,'h11C));
        vecs.push_back(V(1,0,'h124,1,10,0,1,1,0,0,0, 1,0,0,'h55,'h11C));
        vecs.push_back(V(0,1,0,0,0,0,0,0,0,1,'h88888888,
                         0,0,0,'h55,'h11C));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,'h55,'h11C));
        vecs.push_back(V(1,1,'h128,1,11,'h77,0,0,0,0,0, 0,0,0,'h55,'h11C));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,'h55,'h11C));
        vecs.push_back(V(1,0,'h12C,0,12,0,1,0,0,0,0, 1,0,0,'h55,'h11C));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'h13572468,
                         0,0,12,'h13572468,'h12C));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'hFFFFFFFF,
                         1,0,12,'h13572468,'h12C));
        vecs.push_back(V(1,0,'h130,1,13,'h5A,0,0,0,0,0, 1,1,13,'h5A,'h130));
        vecs.push_back(V(0,1,0,0,0,0,0,0,0,0,0, 0,0,13,'h5A,'h130));
        vecs.push_back(V(1,0,'h134,1,14,0,1,7,3,0,0, 1,0,13,'h5A,'h130));
        vecs.push_back(V(0,0,0,0,0,0,0,0,0,1,'h0BADF00D,
                         0,1,14,'h0BADF00D,'h134));
        vecs.push_back(V(1,0,'h138,1,15,0,1,0,0,0,0,
                         1,0,14,'h0BADF00D,'h134));

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.we", 32'(rf_we), 32'd0);
        chk("rst.waddr", 32'(rf_waddr), 32'd0);
        chk("rst.wdata", rf_wdata, 32'd0);
        chk("rst.pc", debug_wb_pc, 32'd0);
        chk("rst.allowin", 32'(wb_allowin), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Reset while the last load is still waiting for its data.
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst.we", 32'(rf_we), 32'd0);
        chk("midrst.waddr", 32'(rf_waddr), 32'd0);
        chk("midrst.wdata", rf_wdata, 32'd0);
        chk("midrst.pc", debug_wb_pc, 32'd0);
        chk("midrst.allowin", 32'(wb_allowin), 32'd1);
        apply(100, V(0,0,0,0,0,0,0,0,0,1,'hCAFEF00D, 1,0,0,0,0));
        apply(101, V(1,0,'h200,1,2,'h42,0,0,0,0,0, 1,1,2,'h42,'h200));

        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL sb.drain: got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
